// File: rtl/data_bus_router.sv
// rtl/data_bus_router.sv - registered CPU read-data router with chip-select decode, wait states and collision flag
// Optional feature macro: DATA_BUS_ROUTER_WAIT_STATES_EN (per-source wait states; undefined = zero wait).
module data_bus_router #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SRC    = 6,
    parameter int WAIT_WIDTH = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          cycle_start,
    input  logic                          read_write,
    input  logic [NUM_SRC-1:0]            cs_n,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    input  logic [NUM_SRC*WAIT_WIDTH-1:0] src_wait,
    input  logic [DATA_WIDTH-1:0]         cpu_data_in,
    input  logic [DATA_WIDTH-1:0]         default_data,
    output logic [DATA_WIDTH-1:0]         output_bus,
    output logic                          data_ready,
    output logic [$clog2(NUM_SRC)-1:0]    sel_index,
    output logic                          collision,
    input  logic                          collision_clr
);

    localparam int SEL_W = $clog2(NUM_SRC);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Where the captured data comes from; latched at cycle_start.
    localparam logic [1:0] MODE_SRC = 2'd0;
    localparam logic [1:0] MODE_DEF = 2'd1;
    localparam logic [1:0] MODE_CPU = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic [WAIT_WIDTH-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic                  rdy_q, rdy_d;
    logic                  coll_q, coll_d;

    logic                  any_low;
    logic                  multi_low;
    logic [SEL_W-1:0]      low_idx;
    logic [WAIT_WIDTH-1:0] wait_sel;
    logic [DATA_WIDTH-1:0] routed;

    // Decode the active-low selects: is any low, is more than one low, which one.
    always_comb begin
        any_low   = 1'b0;
        multi_low = 1'b0;
        low_idx   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!cs_n[i]) begin
                if (any_low) begin
                    multi_low = 1'b1;
                end
                any_low = 1'b1;
                low_idx = SEL_W'(i);
            end
        end
    end

`ifdef DATA_BUS_ROUTER_WAIT_STATES_EN
    // Wait count of the single selected source.
    always_comb begin
        wait_sel = src_wait[int'(low_idx)*WAIT_WIDTH +: WAIT_WIDTH];
    end
`else
    logic unused_src_wait;
    assign unused_src_wait = ^src_wait;

    // Wait states disabled: every cycle completes with one-cycle latency.
    always_comb begin
        wait_sel = '0;
    end
`endif

    // Data presented at the capture edge; sources hold data through the wait window.
    always_comb begin
        case (mode_q)
            MODE_SRC: routed = src_data[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH];
            MODE_CPU: routed = cpu_data_in;
            default:  routed = default_data;
        endcase
    end

    // Cycle control: cycle_start (re)latches from any state, WAIT counts down then captures.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        out_d   = out_q;
        rdy_d   = 1'b0;
        coll_d  = collision_clr ? 1'b0 : coll_q;

        if (cycle_start) begin
            state_d = ST_WAIT;
            if (multi_low) begin
                coll_d = 1'b1;
            end
            sel_d = (any_low && !multi_low) ? low_idx : '0;
            if (!read_write) begin
                mode_d = MODE_CPU;
                cnt_d  = '0;
            end else if (any_low && !multi_low) begin
                mode_d = MODE_SRC;
                cnt_d  = wait_sel;
            end else begin
                mode_d = MODE_DEF;
                cnt_d  = '0;
            end
        end else if (state_q == ST_WAIT) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                out_d   = routed;
                rdy_d   = 1'b1;
                state_d = ST_DONE;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_DEF;
            cnt_q   <= '0;
            sel_q   <= '0;
            out_q   <= '0;
            rdy_q   <= 1'b0;
            coll_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            out_q   <= out_d;
            rdy_q   <= rdy_d;
            coll_q  <= coll_d;
        end
    end

    assign output_bus = out_q;
    assign data_ready = rdy_q;
    assign sel_index  = sel_q;
    assign collision  = coll_q;

endmodule

// File: tb/tb_data_bus_router.sv
// tb/tb_data_bus_router.sv - directed self-checking bench for data_bus_router
module tb_data_bus_router;

`ifdef DATA_BUS_ROUTER_WAIT_STATES_EN
    localparam int WAIT_EN = 1;
`else
    localparam int WAIT_EN = 0;
`endif

    logic        clk;
    logic        reset_n;
    logic        cycle_start;
    logic        read_write;
    logic [5:0]  cs_n;
    logic [47:0] src_data;
    logic [11:0] src_wait;
    logic [7:0]  cpu_data_in;
    logic [7:0]  default_data;
    logic [7:0]  output_bus;
    logic        data_ready;
    logic [2:0]  sel_index;
    logic        collision;
    logic        collision_clr;

    int checks = 0;
    int errors = 0;

    data_bus_router #(.DATA_WIDTH(8), .NUM_SRC(6), .WAIT_WIDTH(2)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cycle_start  (cycle_start),
        .read_write   (read_write),
        .cs_n         (cs_n),
        .src_data     (src_data),
        .src_wait     (src_wait),
        .cpu_data_in  (cpu_data_in),
        .default_data (default_data),
        .output_bus   (output_bus),
        .data_ready   (data_ready),
        .sel_index    (sel_index),
        .collision    (collision),
        .collision_clr(collision_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Start one cycle, then watch a bounded window: lat = samples after the start edge until data_ready.
    task automatic do_cycle(input logic rw, input logic [5:0] cs, input logic clr,
                            output int lat, output int pulses,
                            output logic [7:0] cap_out, output logic [2:0] cap_sel);
        @(negedge clk);
        cycle_start   = 1'b1;
        read_write    = rw;
        cs_n          = cs;
        collision_clr = clr;
        @(negedge clk);
        cycle_start   = 1'b0;
        collision_clr = 1'b0;
        cs_n          = 6'b000000;
        lat     = -1;
        pulses  = 0;
        cap_out = 8'h00;
        cap_sel = 3'd0;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            if (data_ready) begin
                pulses++;
                if (lat < 0) begin
                    lat     = k;
                    cap_out = output_bus;
                    cap_sel = sel_index;
                end
            end
        end
        cs_n = 6'b111111;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (output_bus !== 8'h00) begin errors++; $display("FAIL reset_out actual=%h required=00", output_bus); end
        checks++;
        if (data_ready !== 1'b0) begin errors++; $display("FAIL reset_rdy actual=%b required=0", data_ready); end
        checks++;
        if (sel_index !== 3'd0) begin errors++; $display("FAIL reset_sel actual=%0d required=0", sel_index); end
        checks++;
        if (collision !== 1'b0) begin errors++; $display("FAIL reset_coll actual=%b required=0", collision); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_read;
        int lat, pulses;
        logic [7:0] o;
        logic [2:0] s;
        src_data[15:8] = 8'h3C;
        src_wait[3:2]  = 2'd0;
        do_cycle(1'b1, 6'b111101, 1'b0, lat, pulses, o, s);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL read_lat actual=%0d required=1", lat); end
        checks++;
        if (pulses !== 1) begin errors++; $display("FAIL read_pulses actual=%0d required=1", pulses); end
        checks++;
        if (o !== 8'h3C) begin errors++; $display("FAIL read_out actual=%h required=3c", o); end
        checks++;
        if (s !== 3'd1) begin errors++; $display("FAIL read_sel actual=%0d required=1", s); end
        checks++;
        if (output_bus !== 8'h3C) begin errors++; $display("FAIL read_hold actual=%h required=3c", output_bus); end
    endtask

    task automatic test_wait_states;
        int lat, pulses;
        logic [7:0] o;
        logic [2:0] s;
        src_data[39:32] = 8'h81;
        src_wait[9:8]   = 2'd3;
        do_cycle(1'b1, 6'b101111, 1'b0, lat, pulses, o, s);
        checks++;
        if (lat !== (WAIT_EN ? 4 : 1)) begin errors++; $display("FAIL wait_lat actual=%0d required=%0d", lat, WAIT_EN ? 4 : 1); end
        checks++;
        if (pulses !== 1) begin errors++; $display("FAIL wait_pulses actual=%0d required=1", pulses); end
        checks++;
        if (o !== 8'h81) begin errors++; $display("FAIL wait_out actual=%h required=81", o); end
        checks++;
        if (s !== 3'd4) begin errors++; $display("FAIL wait_sel actual=%0d required=4", s); end
        src_wait[3:2] = 2'd2;
        src_data[15:8] = 8'h96;
        do_cycle(1'b1, 6'b111101, 1'b0, lat, pulses, o, s);
        checks++;
        if (lat !== (WAIT_EN ? 3 : 1)) begin errors++; $display("FAIL wait2_lat actual=%0d required=%0d", lat, WAIT_EN ? 3 : 1); end
        checks++;
        if (o !== 8'h96) begin errors++; $display("FAIL wait2_out actual=%h required=96", o); end
        src_wait[3:2] = 2'd0;
    endtask

    task automatic test_write;
        int lat, pulses;
        logic [7:0] o;
        logic [2:0] s;
        cpu_data_in   = 8'h5A;
        src_data[7:0] = 8'hEE;
        src_wait[1:0] = 2'd3;
        do_cycle(1'b0, 6'b111110, 1'b0, lat, pulses, o, s);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL write_lat actual=%0d required=1", lat); end
        checks++;
        if (o !== 8'h5A) begin errors++; $display("FAIL write_out actual=%h required=5a", o); end
        checks++;
        if (collision !== 1'b0) begin errors++; $display("FAIL write_coll actual=%b required=0", collision); end
        src_wait[1:0] = 2'd0;
    endtask

    task automatic test_no_select_collision;
        int lat, pulses;
        logic [7:0] o;
        logic [2:0] s;
        default_data = 8'h77;
        do_cycle(1'b1, 6'b111111, 1'b0, lat, pulses, o, s);
        checks++;
        if (o !== 8'h77) begin errors++; $display("FAIL nosel_out actual=%h required=77", o); end
        checks++;
        if (s !== 3'd0) begin errors++; $display("FAIL nosel_sel actual=%0d required=0", s); end
        checks++;
        if (collision !== 1'b0) begin errors++; $display("FAIL nosel_coll actual=%b required=0", collision); end
        do_cycle(1'b1, 6'b111100, 1'b0, lat, pulses, o, s);
        checks++;
        if (o !== 8'h77 || lat !== 1) begin errors++; $display("FAIL coll_out actual=%h/%0d required=77/1", o, lat); end
        checks++;
        if (collision !== 1'b1) begin errors++; $display("FAIL coll_set actual=%b required=1", collision); end
        src_data[15:8] = 8'h42;
        do_cycle(1'b1, 6'b111101, 1'b0, lat, pulses, o, s);
        checks++;
        if (collision !== 1'b1 || o !== 8'h42) begin errors++; $display("FAIL coll_sticky actual=%b/%h required=1/42", collision, o); end
        do_cycle(1'b1, 6'b011110, 1'b1, lat, pulses, o, s);
        checks++;
        if (collision !== 1'b1) begin errors++; $display("FAIL coll_set_wins actual=%b required=1", collision); end
        @(negedge clk);
        collision_clr = 1'b1;
        @(negedge clk);
        collision_clr = 1'b0;
        checks++;
        if (collision !== 1'b0) begin errors++; $display("FAIL coll_clear actual=%b required=0", collision); end
    endtask

    task automatic test_abort;
        int lat, pulses;
        src_data[39:32] = 8'h81;
        src_wait[9:8]   = 2'd3;
        src_data[23:16] = 8'h11;
        src_wait[5:4]   = 2'd0;
        @(negedge clk);
        cycle_start = 1'b1;
        read_write  = 1'b1;
        cs_n        = 6'b101111;
        @(negedge clk);
        cs_n        = 6'b111011;
        @(negedge clk);
        cycle_start = 1'b0;
        cs_n        = 6'b111111;
        lat = -1;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            if (data_ready) begin
                pulses++;
                if (lat < 0) lat = k;
            end
        end
        checks++;
        if (pulses !== 1) begin errors++; $display("FAIL abort_pulses actual=%0d required=1", pulses); end
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL abort_lat actual=%0d required=1", lat); end
        checks++;
        if (output_bus !== 8'h11 || sel_index !== 3'd2) begin
            errors++; $display("FAIL abort_out actual=%h/%0d required=11/2", output_bus, sel_index);
        end
    endtask

    task automatic test_mid_reset;
        int lat, pulses;
        logic [7:0] o;
        logic [2:0] s;
        default_data = 8'hA5;
        do_cycle(1'b1, 6'b111100, 1'b0, lat, pulses, o, s);
        checks++;
        if (output_bus !== 8'hA5 || collision !== 1'b1) begin
            errors++; $display("FAIL prereset actual=%h/%b required=a5/1", output_bus, collision);
        end
        @(negedge clk);
        cycle_start = 1'b1;
        read_write  = 1'b1;
        cs_n        = 6'b101111;
        @(negedge clk);
        cycle_start = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (output_bus !== 8'h00 || data_ready !== 1'b0 || collision !== 1'b0 || sel_index !== 3'd0) begin
            errors++;
            $display("FAIL async_reset actual=%h/%b/%b/%0d required=00/0/0/0", output_bus, data_ready, collision, sel_index);
        end
        @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (data_ready) pulses++;
        end
        checks++;
        if (pulses !== 0 || output_bus !== 8'h00) begin
            errors++; $display("FAIL post_reset actual=%0d/%h required=0/00", pulses, output_bus);
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        cycle_start   = 1'b0;
        read_write    = 1'b1;
        cs_n          = 6'b111111;
        src_data      = 48'h0;
        src_wait      = 12'h0;
        cpu_data_in   = 8'h00;
        default_data  = 8'h00;
        collision_clr = 1'b0;
        test_reset;
        test_single_read;
        test_wait_states;
        test_write;
        test_no_select_collision;
        test_abort;
        test_mid_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
